// File: rtl/int_ctrl.sv
// ============================================================================
//  Module   : int_ctrl
//  Purpose  : Edge-latched, maskable interrupt controller driving the fetch
//             ipu_int / int_ack / reti / int_done handshake (no nesting).
//             Optional ack timeout enabled by defining INT_ACK_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module int_ctrl #(
    parameter int N_SRC       = 4,
    parameter int ACK_TIMEOUT = 8,
    localparam int ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic [N_SRC-1:0] mask_q,
    output logic [N_SRC-1:0] pending_q,
    input  logic             jorb,
    input  logic             halt,
    input  logic             ldStall,
    input  logic             reti,
    input  logic             int_ack,
    output logic             ipu_int,
    output logic             int_done,
    output logic [ID_W-1:0]  int_id,
    output logic             busy,
    output logic             ack_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ASSERT   = 3'd1;
    localparam logic [2:0] WAIT_ACK = 3'd2;
    localparam logic [2:0] HANDLER  = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    if (N_SRC < 1 || N_SRC > 16) begin : g_bad_n_src
        $error("int_ctrl: N_SRC must be in 1..16");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
        $error("int_ctrl: ACK_TIMEOUT must be at least 1");
    end

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic             sel_valid;
    logic [ID_W-1:0]  sel_id;
    logic             start;
    logic             ack_fire;
    logic             timeout;

    assign edge_det = irq & ~irq_d;
    assign eligible = pending_q & ~mask_q;
    assign ack_fire = (state == WAIT_ACK) && int_ack;
    // Redirects and stalls hold off the request so fetch saves an on-path PC.
    assign start    = (state == IDLE) && sel_valid && !jorb && !halt && !ldStall && !reti;

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_valid = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr[i] = ack_fire && (int_id == ID_W'(i));
        end
    end

`ifdef INT_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] ack_cnt;
    logic             ack_err_q;

    assign timeout = (state == WAIT_ACK) && !int_ack && (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
    assign ack_err = ack_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_cnt   <= '0;
            ack_err_q <= 1'b0;
        end else begin
            if (state == ASSERT)
                ack_cnt <= '0;
            else if ((state == WAIT_ACK) && !int_ack)
                ack_cnt <= ack_cnt + 1'b1;
            if (timeout)
                ack_err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign ack_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start) state_nxt = ASSERT;
            ASSERT:   state_nxt = WAIT_ACK;
            WAIT_ACK: begin
                if (int_ack)      state_nxt = HANDLER;
                else if (timeout) state_nxt = IDLE;
            end
            HANDLER:  if (reti) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            irq_d     <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            int_id    <= '0;
        end else begin
            state     <= state_nxt;
            irq_d     <= irq;
            // A fresh edge in the clearing cycle keeps the bit set.
            pending_q <= (pending_q & ~clr) | edge_det;
            if (mask_we)
                mask_q <= mask_wdata;
            if (start)
                int_id <= sel_id;
        end
    end

    assign ipu_int  = (state == ASSERT);
    assign int_done = (state == DONE);
    assign busy     = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
//  Module   : tb_int_ctrl
//  Purpose  : Self-checking bench for int_ctrl: vector table with scoreboard
//             plus directed redirect, mid-operation reset and ack-wait cases.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

    typedef struct {
        logic [3:0] irq;
        logic       mask_we;
        logic [3:0] mask_wdata;
        logic       jorb;
        logic       halt;
        logic       ld_stall;
        logic       reti;
        logic       e_ipu;
        logic       e_done;
        logic       e_busy;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
    } vec_t;

    typedef struct {
        logic       ipu;
        logic       done;
        logic       busy;
        logic [1:0] id;
        logic [3:0] pend;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic [3:0] mask_q;
    logic [3:0] pending_q;
    logic       jorb, halt, ldStall, reti;
    logic       int_ack;
    logic       ipu_int, int_done, busy, ack_err;
    logic [1:0] int_id;
    logic       ack_en;

    int checks = 0;
    int passes = 0;

    vec_t vecs[$];
    exp_t sb[$];

    int_ctrl #(.N_SRC(4), .ACK_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .mask_q(mask_q), .pending_q(pending_q), .jorb(jorb), .halt(halt),
        .ldStall(ldStall), .reti(reti), .int_ack(int_ack), .ipu_int(ipu_int),
        .int_done(int_done), .int_id(int_id), .busy(busy), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    // Fetch model: int_ack is a registered copy of ipu_int (gated for the no-ack case).
    always @(posedge clk or negedge rst) begin
        if (!rst) int_ack <= 1'b0;
        else      int_ack <= ipu_int & ack_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        else
            passes++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v(input logic [3:0] i_irq, input logic we, input logic [3:0] wd,
                     input logic j, input logic h, input logic l, input logic r,
                     input logic e_ipu, input logic e_done, input logic e_busy,
                     input logic [1:0] e_id, input logic [3:0] e_pend, input logic [3:0] e_mask);
        vec_t t;
        t.irq = i_irq; t.mask_we = we; t.mask_wdata = wd;
        t.jorb = j; t.halt = h; t.ld_stall = l; t.reti = r;
        t.e_ipu = e_ipu; t.e_done = e_done; t.e_busy = e_busy;
        t.e_id = e_id; t.e_pend = e_pend; t.e_mask = e_mask;
        vecs.push_back(t);
    endtask

    initial begin
        exp_t e;
        // irq we wd j h l r | ipu done busy id pend mask  (outputs after the edge)
        v(4'h0,1,4'h0,0,0,0,0, 0,0,0,0,4'h0,4'h0);  // unmask all
        v(4'h4,0,4'h0,0,0,0,0, 0,0,0,0,4'h4,4'h0);  // irq[2] edge latched
        v(4'h4,0,4'h0,0,0,0,0, 1,0,1,2,4'h4,4'h0);  // ASSERT
        v(4'h4,0,4'h0,0,0,0,0, 0,0,1,2,4'h4,4'h0);  // WAIT_ACK
        v(4'h4,0,4'h0,0,0,0,0, 0,0,1,2,4'h0,4'h0);  // ack -> HANDLER, clear
        v(4'h0,0,4'h0,0,0,0,0, 0,0,1,2,4'h0,4'h0);
        v(4'h0,0,4'h0,0,0,0,1, 0,1,1,2,4'h0,4'h0);  // reti -> DONE
        v(4'h0,0,4'h0,0,0,0,0, 0,0,0,2,4'h0,4'h0);  // IDLE
        v(4'hA,0,4'h0,0,0,0,0, 0,0,0,2,4'hA,4'h0);  // irq[1], irq[3] together
        v(4'hA,0,4'h0,0,0,0,0, 1,0,1,1,4'hA,4'h0);  // lowest index first
        v(4'hA,0,4'h0,0,0,0,0, 0,0,1,1,4'hA,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 0,0,1,1,4'h8,4'h0);
        v(4'hA,0,4'h0,0,0,0,1, 0,1,1,1,4'h8,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 0,0,0,1,4'h8,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 1,0,1,3,4'h8,4'h0);  // id 3 right after IDLE
        v(4'hA,0,4'h0,0,0,0,0, 0,0,1,3,4'h8,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 0,0,1,3,4'h0,4'h0);
        v(4'hA,0,4'h0,0,0,0,1, 0,1,1,3,4'h0,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 0,0,0,3,4'h0,4'h0);
        v(4'hB,1,4'h1,0,0,0,0, 0,0,0,3,4'h1,4'h1);  // masked source still latches
        v(4'hB,0,4'h0,0,0,0,0, 0,0,0,3,4'h1,4'h1);
        v(4'hB,1,4'h0,0,0,0,0, 0,0,0,3,4'h1,4'h0);  // unmask
        v(4'hB,0,4'h0,0,0,0,0, 1,0,1,0,4'h1,4'h0);
        v(4'hA,0,4'h0,0,0,0,0, 0,0,1,0,4'h1,4'h0);  // irq[0] drops
        v(4'hB,0,4'h0,0,0,0,0, 0,0,1,0,4'h1,4'h0);  // re-edge during clear wins
        v(4'hB,0,4'h0,0,0,0,1, 0,1,1,0,4'h1,4'h0);
        v(4'hB,0,4'h0,0,0,0,0, 0,0,0,0,4'h1,4'h0);
        v(4'hB,0,4'h0,0,0,0,1, 0,0,0,0,4'h1,4'h0);  // reti in IDLE blocks start
        v(4'hB,0,4'h0,0,0,0,0, 1,0,1,0,4'h1,4'h0);
        v(4'hB,0,4'h0,0,0,0,0, 0,0,1,0,4'h1,4'h0);
        v(4'hB,0,4'h0,0,0,0,0, 0,0,1,0,4'h0,4'h0);
        v(4'hB,0,4'h0,0,0,0,1, 0,1,1,0,4'h0,4'h0);
        v(4'hB,0,4'h0,0,0,0,0, 0,0,0,0,4'h0,4'h0);
        v(4'hF,0,4'h0,0,1,0,0, 0,0,0,0,4'h4,4'h0);  // irq[2] edge under halt
        v(4'hF,0,4'h0,0,1,0,0, 0,0,0,0,4'h4,4'h0);  // halt blocks
        v(4'hF,0,4'h0,0,0,1,0, 0,0,0,0,4'h4,4'h0);  // ldStall blocks
        v(4'hF,0,4'h0,0,0,0,0, 1,0,1,2,4'h4,4'h0);
        v(4'hF,0,4'h0,0,0,0,0, 0,0,1,2,4'h4,4'h0);
        v(4'hF,0,4'h0,0,0,0,0, 0,0,1,2,4'h0,4'h0);
        v(4'hF,0,4'h0,0,0,0,1, 0,1,1,2,4'h0,4'h0);
        v(4'hF,0,4'h0,0,0,0,0, 0,0,0,2,4'h0,4'h0);

        rst = 1'b0; irq = '0; mask_we = 0; mask_wdata = '0;
        jorb = 0; halt = 0; ldStall = 0; reti = 0; ack_en = 1'b1;
        #12;
        chk("rst_ipu",     0, {7'd0, ipu_int},  8'd0);
        chk("rst_done",    0, {7'd0, int_done}, 8'd0);
        chk("rst_busy",    0, {7'd0, busy},     8'd0);
        chk("rst_mask",    0, {4'd0, mask_q},   8'h0F);
        chk("rst_pending", 0, {4'd0, pending_q},8'h00);
        chk("rst_id",      0, {6'd0, int_id},   8'd0);
        chk("rst_ack_err", 0, {7'd0, ack_err},  8'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            irq = vecs[i].irq; mask_we = vecs[i].mask_we; mask_wdata = vecs[i].mask_wdata;
            jorb = vecs[i].jorb; halt = vecs[i].halt; ldStall = vecs[i].ld_stall; reti = vecs[i].reti;
            e.ipu = vecs[i].e_ipu; e.done = vecs[i].e_done; e.busy = vecs[i].e_busy;
            e.id = vecs[i].e_id; e.pend = vecs[i].e_pend; e.mask = vecs[i].e_mask;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            chk("ipu_int",   i, {7'd0, ipu_int},   {7'd0, e.ipu});
            chk("int_done",  i, {7'd0, int_done},  {7'd0, e.done});
            chk("busy",      i, {7'd0, busy},      {7'd0, e.busy});
            chk("int_id",    i, {6'd0, int_id},    {6'd0, e.id});
            chk("pending_q", i, {4'd0, pending_q}, {4'd0, e.pend});
            chk("mask_q",    i, {4'd0, mask_q},    {4'd0, e.mask});
        end
        mask_we = 0; reti = 0; jorb = 0; halt = 0; ldStall = 0;

        // Branch redirect held for three cycles delays the request.
        irq = 4'hE; tick();
        chk("jorb_pre_busy", 0, {7'd0, busy}, 8'd0);
        irq = 4'hF; jorb = 1'b1; tick();
        chk("jorb_pend", 0, {4'd0, pending_q}, 8'h01);
        chk("jorb_ipu",  0, {7'd0, ipu_int}, 8'd0);
        tick(); chk("jorb_ipu", 1, {7'd0, ipu_int}, 8'd0);
        tick(); chk("jorb_ipu", 2, {7'd0, ipu_int}, 8'd0);
        jorb = 1'b0; tick();
        chk("jorb_release_ipu", 0, {7'd0, ipu_int}, 8'd1);
        chk("jorb_release_id",  0, {6'd0, int_id},  8'd0);
        tick(); chk("jorb_wait_busy", 0, {7'd0, busy}, 8'd1);
        tick(); chk("jorb_handler_pend", 0, {4'd0, pending_q}, 8'h00);

        // New request during the handler, then reset mid-operation.
        irq = 4'hD; tick();
        irq = 4'hF; tick();
        chk("handler_pend", 0, {4'd0, pending_q}, 8'h02);
        chk("handler_ipu",  0, {7'd0, ipu_int},   8'd0);
        #3 rst = 1'b0;
        #1;
        chk("midrst_busy", 0, {7'd0, busy},      8'd0);
        chk("midrst_pend", 0, {4'd0, pending_q}, 8'h00);
        chk("midrst_mask", 0, {4'd0, mask_q},    8'h0F);
        chk("midrst_ipu",  0, {7'd0, ipu_int},   8'd0);
        irq = 4'h0;
        #1 rst = 1'b1;

        // Request serviced with fetch never acknowledging.
        ack_en = 1'b0;
        irq = 4'h2; mask_we = 1'b1; mask_wdata = 4'h0; tick();
        mask_we = 1'b0;
        chk("noack_pend", 0, {4'd0, pending_q}, 8'h02);
        tick(); chk("noack_ipu", 0, {7'd0, ipu_int}, 8'd1);
        tick(); chk("noack_wait", 0, {7'd0, busy}, 8'd1);
`ifdef INT_ACK_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("to_wait_busy", k, {7'd0, busy},    8'd1);
            chk("to_wait_err",  k, {7'd0, ack_err}, 8'd0);
        end
        tick();
        chk("to_idle_busy", 0, {7'd0, busy},      8'd0);
        chk("to_ack_err",   0, {7'd0, ack_err},   8'd1);
        chk("to_pend_kept", 0, {4'd0, pending_q}, 8'h02);
        tick();
        chk("to_reassert_ipu", 0, {7'd0, ipu_int}, 8'd1);
        chk("to_reassert_id",  0, {6'd0, int_id},  8'd1);
        chk("to_err_sticky",   0, {7'd0, ack_err}, 8'd1);
`else
        for (int k = 0; k < 12; k++) tick();
        chk("noack_still_busy", 0, {7'd0, busy},      8'd1);
        chk("noack_ack_err",    0, {7'd0, ack_err},   8'd0);
        chk("noack_pend_kept",  0, {4'd0, pending_q}, 8'h02);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
